// File: rtl/lerp_unit.sv
// ----------------------------------------------------------------------------
// lerp_unit
// Fixed-point linear interpolator:
//   result = y0 + (x - x0) * (y1 - y0) / (x1 - x0), with FRAC fractional bits.
// x outside [x0, x1] is clamped to the nearer end value. An empty or inverted
// interval (x0 >= x1) is flagged on err. The quotient is produced by a
// bit-serial restoring divider, one bit per cycle.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   operation request, sampled only while busy = 0
//   x,x0,x1  in   query point and interval ends (XW bits, unsigned)
//   y0,y1    in   values at x0 and x1 (YW bits, unsigned)
//   busy     out  operation in progress
//   done     out  one-cycle pulse; result and err valid
//   err      out  x0 >= x1 seen; held until the next done
//   result   out  interpolant (YW+FRAC bits), held until the next done
// ----------------------------------------------------------------------------
module lerp_unit #(
    parameter int XW   = 16,
    parameter int YW   = 16,
    parameter int FRAC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [XW-1:0]      x,
    input  logic [XW-1:0]      x0,
    input  logic [XW-1:0]      x1,
    input  logic [YW-1:0]      y0,
    input  logic [YW-1:0]      y1,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [YW+FRAC-1:0] result
);

    localparam int NW = XW + YW + FRAC;
    localparam int RW = YW + FRAC;
    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic [XW-1:0]   x_r;
    logic [XW-1:0]   x0_r;
    logic [XW-1:0]   x1_r;
    logic [YW-1:0]   y0_r;
    logic [YW-1:0]   y1_r;

    logic [NW-1:0]   n_r;
    logic [RW-1:0]   q_r;
    logic [XW:0]     rem_r;
    logic [XW-1:0]   dd_r;
    logic [RW-1:0]   base_r;
    logic            sign_r;
    logic            err_pend_r;
    logic [CW-1:0]   cnt_r;

    logic [XW-1:0]    dx_s;
    logic [XW-1:0]    dd_s;
    logic [YW-1:0]    dy_s;
    logic             sign_s;
    logic [XW+YW-1:0] prod_s;
    logic             bad_s;
    logic             lo_s;
    logic             hi_s;
    logic [XW:0]      rem_sh_s;
    logic             ge_s;
    logic [XW:0]      rem_nx_s;
    logic             last_s;
    logic [RW-1:0]    fin_result_s;

    // LOAD-stage arithmetic on the captured operands
    always_comb begin
        sign_s = (y1_r < y0_r);
        dx_s   = x_r - x0_r;
        dd_s   = x1_r - x0_r;
        if (sign_s) begin
            dy_s = y0_r - y1_r;
        end else begin
            dy_s = y1_r - y0_r;
        end
        prod_s = {{YW{1'b0}}, dx_s} * {{XW{1'b0}}, dy_s};
        bad_s  = (x0_r >= x1_r);
        lo_s   = (x_r <= x0_r);
        hi_s   = (x_r >= x1_r);
    end

    // One restoring-division step; the stored remainder is always < dd, so
    // dropping its top bit on the shift loses nothing
    always_comb begin
        rem_sh_s = (XW+1)'({rem_r, n_r[NW-1]});
        ge_s     = (rem_sh_s >= {1'b0, dd_r});
        if (ge_s) begin
            rem_nx_s = rem_sh_s - {1'b0, dd_r};
        end else begin
            rem_nx_s = rem_sh_s;
        end
        last_s = (cnt_r == CW'(NW - 1));
    end

    // Final value: the quotient never exceeds |dy|*2^FRAC, so it fits RW bits
    // and the sum/difference stays between y0 and y1
    always_comb begin
        if (sign_r) begin
            fin_result_s = base_r - q_r;
        end else begin
            fin_result_s = base_r + q_r;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_LOAD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bad_s || lo_s || hi_s) begin
                    state_nx_s = S_FIN;
                end else begin
                    state_nx_s = S_DIV;
                end
            end
            S_DIV: begin
                if (last_s) begin
                    state_nx_s = S_FIN;
                end else begin
                    state_nx_s = S_DIV;
                end
            end
            S_FIN:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r        <= {XW{1'b0}};
            x0_r       <= {XW{1'b0}};
            x1_r       <= {XW{1'b0}};
            y0_r       <= {YW{1'b0}};
            y1_r       <= {YW{1'b0}};
            n_r        <= {NW{1'b0}};
            q_r        <= {RW{1'b0}};
            rem_r      <= {(XW+1){1'b0}};
            dd_r       <= {XW{1'b0}};
            base_r     <= {RW{1'b0}};
            sign_r     <= 1'b0;
            err_pend_r <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= {RW{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        x_r  <= x;
                        x0_r <= x0;
                        x1_r <= x1;
                        y0_r <= y0;
                        y1_r <= y1;
                        busy <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    n_r    <= {prod_s, {FRAC{1'b0}}};
                    dd_r   <= dd_s;
                    q_r    <= {RW{1'b0}};
                    rem_r  <= {(XW+1){1'b0}};
                    cnt_r  <= {CW{1'b0}};
                    // Shortcuts finish with a zero quotient, so base is the answer
                    if (bad_s) begin
                        err_pend_r <= 1'b1;
                        sign_r     <= 1'b0;
                        base_r     <= {y0_r, {FRAC{1'b0}}};
                    end else if (lo_s) begin
                        err_pend_r <= 1'b0;
                        sign_r     <= 1'b0;
                        base_r     <= {y0_r, {FRAC{1'b0}}};
                    end else if (hi_s) begin
                        err_pend_r <= 1'b0;
                        sign_r     <= 1'b0;
                        base_r     <= {y1_r, {FRAC{1'b0}}};
                    end else begin
                        err_pend_r <= 1'b0;
                        sign_r     <= sign_s;
                        base_r     <= {y0_r, {FRAC{1'b0}}};
                    end
                end
                S_DIV: begin
                    rem_r <= rem_nx_s;
                    q_r   <= {q_r[RW-2:0], ge_s};
                    n_r   <= {n_r[NW-2:0], 1'b0};
                    if (last_s) begin
                        cnt_r <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIN: begin
                    result <= fin_result_s;
                    err    <= err_pend_r;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lerp_unit.sv
module tb_lerp_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] x, x0, x1, y0, y1;
    logic        busy, done, err;
    logic [23:0] result;

    int compared;
    int mismatched;
    int lat;
    int done_seen;

    lerp_unit #(.XW(16), .YW(16), .FRAC(8)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .x      (x),
        .x0     (x0),
        .x1     (x1),
        .y0     (y0),
        .y1     (y1),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive operands with start for one cycle; returns at the negedge after E0.
    task automatic issue(input logic [15:0] xv, input logic [15:0] x0v, input logic [15:0] x1v,
                         input logic [15:0] y0v, input logic [15:0] y1v);
        x = xv; x0 = x0v; x1 = x1v; y0 = y0v; y1 = y1v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts negedges since the start cycle.
    task automatic wait_done(input int lat_in, output int lat_out);
        int l;
        l = lat_in;
        while (done !== 1'b1 && l < 200) begin
            @(negedge clk);
            l++;
        end
        lat_out = l;
    endtask

    task automatic run(input string tag, input logic [15:0] xv, input logic [15:0] x0v,
                       input logic [15:0] x1v, input logic [15:0] y0v, input logic [15:0] y1v,
                       input int exp_res, input int exp_err, input int exp_lat);
        int l;
        issue(xv, x0v, x1v, y0v, y1v);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(1, l);
        check({tag, "_lat"}, l, exp_lat);
        check({tag, "_result"}, {8'd0, result}, exp_res);
        check({tag, "_err"}, {31'd0, err}, exp_err);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n = 1'b0;
        start = 1'b0;
        x = 16'd0; x0 = 16'd0; x1 = 16'd0; y0 = 16'd0; y1 = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_err",    {31'd0, err},  32'd0);
        check("rst_result", {8'd0, result}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("interior", 16'd15, 16'd10, 16'd20, 16'd100, 16'd200, 38400, 0, 43);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_busy",  {31'd0, busy}, 32'd0);
        check("held_result", {8'd0, result}, 32'd38400);

        run("decreasing", 16'd13, 16'd10, 16'd20, 16'd200, 16'd100, 43520, 0, 43);
        // each following run issues start in the done cycle of the previous one
        run("frac_up",   16'd1,  16'd0,  16'd3,  16'd0,   16'd1,   85,    0, 43);
        run("frac_down", 16'd1,  16'd0,  16'd3,  16'd1,   16'd0,   171,   0, 43);
        run("clamp_lo",  16'd5,  16'd10, 16'd20, 16'd100, 16'd200, 25600, 0, 3);
        run("clamp_hi",  16'd25, 16'd10, 16'd20, 16'd100, 16'd200, 51200, 0, 3);
        run("degen",     16'd7,  16'd7,  16'd7,  16'd9,   16'd50,  2304,  1, 3);

        // err held while the next op runs, cleared by its done
        issue(16'd15, 16'd10, 16'd20, 16'd100, 16'd200);
        check("err_held_busy", {31'd0, err}, 32'd1);
        check("err_held_result", {8'd0, result}, 32'd2304);
        wait_done(1, lat);
        check("err_clear_lat", lat, 43);
        check("err_clear_err", {31'd0, err}, 32'd0);
        check("err_clear_result", {8'd0, result}, 32'd38400);

        // start pulses while busy must be ignored
        repeat (3) @(negedge clk);
        issue(16'd13, 16'd10, 16'd20, 16'd200, 16'd100);
        repeat (4) @(negedge clk);
        x = 16'd25; y0 = 16'd0; y1 = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        x = 16'd1; x0 = 16'd1; x1 = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(21, lat);
        check("ign_lat", lat, 43);
        check("ign_result", {8'd0, result}, 32'd43520);
        check("ign_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("ign_no_second_busy", {31'd0, busy}, 32'd0);

        // reset during DIV cycle 20
        issue(16'd15, 16'd10, 16'd20, 16'd100, 16'd200);
        repeat (21) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",   {31'd0, busy}, 32'd0);
        check("mid_rst_result", {8'd0, result}, 32'd0);
        check("mid_rst_done",   {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        check("idle_after_rst_result", {8'd0, result}, 32'd0);

        run("recover", 16'd15, 16'd10, 16'd20, 16'd100, 16'd200, 38400, 0, 43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lerp_unit.md
# lerp_unit

Parametrised fixed-point linear interpolator computing y = y0 + (x − x0)·(y1 − y0)/(x1 − x0) with a FRAC-bit fractional result. It is the next-generation interpolation datapath: widths are generic, y may increase or decrease, out-of-range x is clamped, and a zero-width interval is flagged. Division is a bit-serial restoring divider, and operands are captured on a start/busy/done handshake. The block sits between the table-lookup stage, which supplies the bracketing points, and the result writer.

## Interface
- XW, 16, width of x, x0, x1 (unsigned)
- YW, 16, width of y0, y1 (unsigned)
- FRAC, 8, fractional bits in result
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  request; sampled only when busy=0
- x, x0, x1  in  XW  query point and interval ends
- y0, y1  in  YW  values at x0, x1
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result/err valid
- err  out  1  x0 ≥ x1 detected; valid with done, held until next done
- result  out  YW+FRAC  unsigned fixed-point interpolant, held until next done

## Operation
- NW = XW+YW+FRAC (divider iterations; 40 at defaults).
- States: IDLE, LOAD, DIV, FIN.
- IDLE → LOAD on start=1: register all operands; busy=1 from the next cycle.
- LOAD, single cycle:
  - Compute dx = x−x0, dd = x1−x0 (XW bits), |dy| = |y1−y0| (YW bits) and sign = (y1<y0).
  - Register numerator N = dx·|dy|·2^FRAC (NW bits).
  - Clear the quotient and remainder (remainder XW+1 bits).
- LOAD shortcut cases, in priority order:
  - If x0 ≥ x1: err=1, result = y0·2^FRAC, go to FIN.
  - Else if x ≤ x0: result = y0·2^FRAC, go to FIN.
  - Else if x ≥ x1: result = y1·2^FRAC, go to FIN.
  - Otherwise go to DIV.
- DIV, NW cycles (counter 0..NW−1):
  - Shift the remainder left and bring in the next N bit (MSB first).
  - If remainder ≥ dd, subtract dd and shift in quotient 1; else shift in 0.
  - On the last iteration go to FIN.
- FIN:
  - q = quotient, truncated, ≤ |dy|·2^FRAC.
  - result = y0·2^FRAC + q if sign=0, else y0·2^FRAC − q. This always lands in [min, max]·2^FRAC, so no overflow is possible.
  - Rounding is therefore truncation toward y0.
  - Pulse done, clear busy, return to IDLE.
- start while busy=1 is ignored; no queueing.
- Operand inputs may change after the start cycle; only the captured values are used.

## Timing
- Reset values: busy=0, done=0, err=0, result=0, state IDLE, counters 0.
- Start sampled at edge E0.
- Normal path: done=1 in the cycle after edge E0+NW+2, i.e. NW+3 cycles after the start cycle (43 at defaults).
- Shortcut path (clamp or err): done 3 cycles after the start cycle, with no DIV cycles.
- busy is high from the cycle after E0 through the FIN cycle, and low in the done cycle.
- A new start is accepted in the same cycle done is high (back-to-back operation). Its busy rises the next cycle.
- err and result update only at done. err is cleared by any non-err done.
- Reset mid-operation aborts immediately: all outputs go to reset values, no done is issued, and result is cleared.

## Test plan
- Interior point: x0=10, x1=20, y0=100, y1=200, x=15 → done after 43 cycles, result=38400 (150·256), err=0.
- Decreasing interval: x0=10, x1=20, y0=200, y1=100, x=13 → result=43520 (170·256).
- Fraction and truncation: x0=0, x1=3, y0=0, y1=1, x=1 → result=85; with y0=1, y1=0 → result=171 (256−85).
- Clamping: x0=10, x1=20, y0=100, y1=200:
  - x=5 → result=25600, done 3 cycles after start.
  - x=25 → result=51200.
  - err=0 in both cases.
- Degenerate interval: x0=x1=7, y0=9 → err=1, result=2304, done 3 cycles after start. The next valid op clears err.
- Handshake and reset:
  - start pulses during busy are ignored, and result matches the first op.
  - start asserted in the done cycle is accepted.
  - reset_n low at DIV cycle 20 → busy=0, result=0, no done.
